// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared definitions for the ID/EX pipeline stage. Covers the
//               datapath widths, the register-zero address, the ALU operation
//               codes, the layout of the EX register and the bubble value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 5;
    localparam int SA_W       = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // ALU operation codes. The NOP code is zero so that a bubble, which is
    // all zeros, decodes as a no-op.
    localparam logic [ALUOP_W-1:0] ALU_NOP = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_AND = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 5'd9;
    localparam logic [ALUOP_W-1:0] ALU_SRA = 5'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 5'd11;

    // Contents of the EX register.
    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [XLEN-1:0]       rs_val;
        logic [XLEN-1:0]       rt_val;
        logic [XLEN-1:0]       imm_ext;
        logic [SA_W-1:0]       sa;
        logic                  use_sa;
        logic                  use_imm;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_we;
        logic                  mem_re;
        logic                  mem_we;
    } ex_entry_t;

    // A bubble clears every field, control and data alike.
    function automatic ex_entry_t bubble_entry();
        ex_entry_t b;
        b = '0;
        return b;
    endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle between the ID stage / forwarding network and the
//               ID/EX stage.
//               The master modport belongs to the side that drives the decoded
//               instruction, stall/flush and forward triples. The slave
//               modport is the ID/EX stage itself, which returns the EX-stage
//               outputs and the load-use hazard.
// Ports       : none (interface); see the modports below.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    // Pipeline control
    logic                  stall;
    logic                  flush;

    // Decoded instruction from ID
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [ALUOP_W-1:0]    id_aluop;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [XLEN-1:0]       id_rs_val;
    logic [XLEN-1:0]       id_rt_val;
    logic [XLEN-1:0]       id_imm_ext;
    logic [SA_W-1:0]       id_sa;
    logic                  id_use_sa;
    logic                  id_use_imm;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_reg_we;
    logic                  id_mem_re;
    logic                  id_mem_we;

    // Forwarding sources
    logic                  mem_fwd_we;
    logic [REG_ADDR_W-1:0] mem_fwd_addr;
    logic [XLEN-1:0]       mem_fwd_data;
    logic                  wb_fwd_we;
    logic [REG_ADDR_W-1:0] wb_fwd_addr;
    logic [XLEN-1:0]       wb_fwd_data;

    // Stage outputs
    logic                  ld_use_hazard;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [ALUOP_W-1:0]    ALUop;
    logic [XLEN-1:0]       ALUopnd1;
    logic [XLEN-1:0]       ALUopnd2;
    logic [XLEN-1:0]       ex_store_data;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_reg_we;
    logic                  ex_mem_re;
    logic                  ex_mem_we;

    modport master (
        output stall, flush,
        output id_valid, id_pc, id_aluop, id_rs_addr, id_rt_addr,
               id_rs_val, id_rt_val, id_imm_ext, id_sa, id_use_sa,
               id_use_imm, id_dest, id_reg_we, id_mem_re, id_mem_we,
        output mem_fwd_we, mem_fwd_addr, mem_fwd_data,
               wb_fwd_we, wb_fwd_addr, wb_fwd_data,
        input  ld_use_hazard, ex_valid, ex_pc, ALUop, ALUopnd1, ALUopnd2,
               ex_store_data, ex_dest, ex_reg_we, ex_mem_re, ex_mem_we
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_aluop, id_rs_addr, id_rt_addr,
               id_rs_val, id_rt_val, id_imm_ext, id_sa, id_use_sa,
               id_use_imm, id_dest, id_reg_we, id_mem_re, id_mem_we,
        input  mem_fwd_we, mem_fwd_addr, mem_fwd_data,
               wb_fwd_we, wb_fwd_addr, wb_fwd_data,
        output ld_use_hazard, ex_valid, ex_pc, ALUop, ALUopnd1, ALUopnd2,
               ex_store_data, ex_dest, ex_reg_we, ex_mem_re, ex_mem_we
    );

endinterface : id_ex_stage_if
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand forwarding selector for one source register.
//               A matching EX/MEM result beats a matching MEM/WB result.
//               Register zero is never forwarded. With no match, the stored
//               value passes through.
// Ports       : src_addr/src_val             - source register and its
//                                              stored value
//               mem_we/mem_addr/mem_data     - EX/MEM forward triple
//               wb_we/wb_addr/wb_data        - MEM/WB forward triple
//               fwd_val                      - forwarded operand
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  wire logic [REG_ADDR_W-1:0] src_addr,
    input  wire logic [XLEN-1:0]       src_val,
    input  wire logic                  mem_we,
    input  wire logic [REG_ADDR_W-1:0] mem_addr,
    input  wire logic [XLEN-1:0]       mem_data,
    input  wire logic                  wb_we,
    input  wire logic [REG_ADDR_W-1:0] wb_addr,
    input  wire logic [XLEN-1:0]       wb_data,
    output logic      [XLEN-1:0]       fwd_val
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_we && (mem_addr == src_addr) && (src_addr != REG_ZERO);
    assign wb_hit  = wb_we  && (wb_addr  == src_addr) && (src_addr != REG_ZERO);

    always_comb begin
        fwd_val = src_val;
        if (mem_hit) begin
            fwd_val = mem_data;
        end else if (wb_hit) begin
            fwd_val = wb_data;
        end
    end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the 5-stage MIPS core.
//               It captures the decoded operands and control from ID. It
//               inserts a bubble on flush or on a load-use hazard and holds
//               on stall. It forwards MEM/WB results into the operands and
//               drives the EX-stage ALU operand and opcode buses directly.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - id_ex_stage_if.slave: ID inputs, stall/flush, forward
//                      triples in; ex_* outputs, ALUop/ALUopnd1/ALUopnd2 and
//                      ld_use_hazard out
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    id_ex_stage_if.slave   bus
);

    ex_entry_t       ex_reg;
    ex_entry_t       id_entry;
    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;
    logic            hazard_raw;
    logic            hazard;

    // Decoded instruction as it would be stored on a normal load.
    always_comb begin
        id_entry         = bubble_entry();
        id_entry.valid   = bus.id_valid;
        id_entry.pc      = bus.id_pc;
        id_entry.aluop   = bus.id_aluop;
        id_entry.rs_addr = bus.id_rs_addr;
        id_entry.rt_addr = bus.id_rt_addr;
        id_entry.rs_val  = bus.id_rs_val;
        id_entry.rt_val  = bus.id_rt_val;
        id_entry.imm_ext = bus.id_imm_ext;
        id_entry.sa      = bus.id_sa;
        id_entry.use_sa  = bus.id_use_sa;
        id_entry.use_imm = bus.id_use_imm;
        id_entry.dest    = bus.id_dest;
        id_entry.reg_we  = bus.id_reg_we;
        id_entry.mem_re  = bus.id_mem_re;
        id_entry.mem_we  = bus.id_mem_we;
    end

    // Forwarding acts on the stored EX operands.
    fwd_mux u_fwd_rs (
        .src_addr (ex_reg.rs_addr),
        .src_val  (ex_reg.rs_val),
        .mem_we   (bus.mem_fwd_we),
        .mem_addr (bus.mem_fwd_addr),
        .mem_data (bus.mem_fwd_data),
        .wb_we    (bus.wb_fwd_we),
        .wb_addr  (bus.wb_fwd_addr),
        .wb_data  (bus.wb_fwd_data),
        .fwd_val  (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .src_addr (ex_reg.rt_addr),
        .src_val  (ex_reg.rt_val),
        .mem_we   (bus.mem_fwd_we),
        .mem_addr (bus.mem_fwd_addr),
        .mem_data (bus.mem_fwd_data),
        .wb_we    (bus.wb_fwd_we),
        .wb_addr  (bus.wb_fwd_addr),
        .wb_data  (bus.wb_fwd_data),
        .fwd_val  (fwd_rt)
    );

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time. ID must hold for one cycle while a bubble goes in.
    assign hazard_raw = ex_reg.valid && ex_reg.mem_re && (ex_reg.dest != REG_ZERO) &&
                        bus.id_valid &&
                        ((ex_reg.dest == bus.id_rs_addr) || (ex_reg.dest == bus.id_rt_addr));

    // Stall and flush already hold or squash the whole stage. A hazard
    // reported on top of either would make ID hold twice.
    assign hazard = hazard_raw && !bus.stall && !bus.flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg <= bubble_entry();
        end else if (bus.flush) begin
            ex_reg <= bubble_entry();
        end else if (bus.stall) begin
            // Keep the forwarded values while holding. A producer that
            // retires from WB during a long stall is then still visible
            // after it has left the forwarding network.
            ex_reg.rs_val <= fwd_rs;
            ex_reg.rt_val <= fwd_rt;
        end else if (hazard) begin
            ex_reg <= bubble_entry();
        end else begin
            ex_reg <= id_entry;
        end
    end

    assign bus.ld_use_hazard = hazard;
    assign bus.ex_valid      = ex_reg.valid;
    assign bus.ex_pc         = ex_reg.pc;
    assign bus.ALUop         = ex_reg.aluop;
    assign bus.ex_dest       = ex_reg.dest;
    assign bus.ex_reg_we     = ex_reg.reg_we;
    assign bus.ex_mem_re     = ex_reg.mem_re;
    assign bus.ex_mem_we     = ex_reg.mem_we;

    // The operand buses are gated by rst. They then read zero while reset is
    // held, even before the first edge clears the register.
    assign bus.ALUopnd1      = rst ? '0 :
                               (ex_reg.use_sa  ? {{(XLEN-SA_W){1'b0}}, ex_reg.sa} : fwd_rs);
    assign bus.ALUopnd2      = rst ? '0 :
                               (ex_reg.use_imm ? ex_reg.imm_ext : fwd_rt);
    assign bus.ex_store_data = rst ? '0 : fwd_rt;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage. It covers reset,
//               a plain load, forward priority, the load-use bubble, the stall
//               refresh, flush over stall, a shift-amount operand and reset
//               during a stall.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge, then move just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(
        input logic        valid,
        input logic [31:0] pc,
        input logic [4:0]  aluop,
        input logic [4:0]  rs,
        input logic [31:0] rs_val,
        input logic [4:0]  rt,
        input logic [31:0] rt_val,
        input logic [31:0] imm,
        input logic [4:0]  sa,
        input logic        use_sa,
        input logic        use_imm,
        input logic [4:0]  dest,
        input logic        reg_we,
        input logic        mem_re,
        input logic        mem_we
    );
        bus.id_valid   = valid;
        bus.id_pc      = pc;
        bus.id_aluop   = aluop;
        bus.id_rs_addr = rs;
        bus.id_rs_val  = rs_val;
        bus.id_rt_addr = rt;
        bus.id_rt_val  = rt_val;
        bus.id_imm_ext = imm;
        bus.id_sa      = sa;
        bus.id_use_sa  = use_sa;
        bus.id_use_imm = use_imm;
        bus.id_dest    = dest;
        bus.id_reg_we  = reg_we;
        bus.id_mem_re  = mem_re;
        bus.id_mem_we  = mem_we;
    endtask

    task automatic clear_fwd();
        bus.mem_fwd_we   = 1'b0;
        bus.mem_fwd_addr = 5'd0;
        bus.mem_fwd_data = 32'h0;
        bus.wb_fwd_we    = 1'b0;
        bus.wb_fwd_addr  = 5'd0;
        bus.wb_fwd_data  = 32'h0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with garbage on every input.
        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b1, 32'hDEADBEEF, ALU_SUB, 5'd7, 32'h11111111, 5'd9, 32'h22222222,
                 32'h33333333, 5'd17, 1'b1, 1'b1, 5'd21, 1'b1, 1'b1, 1'b1);
        bus.mem_fwd_we   = 1'b1;
        bus.mem_fwd_addr = 5'd7;
        bus.mem_fwd_data = 32'hA5A5A5A5;
        bus.wb_fwd_we    = 1'b1;
        bus.wb_fwd_addr  = 5'd9;
        bus.wb_fwd_data  = 32'h5A5A5A5A;
        tick();
        tick();
        check("rst_valid",   32'(bus.ex_valid),  32'd0);
        check("rst_pc",      bus.ex_pc,          32'd0);
        check("rst_aluop",   32'(bus.ALUop),     32'd0);
        check("rst_opnd1",   bus.ALUopnd1,       32'd0);
        check("rst_opnd2",   bus.ALUopnd2,       32'd0);
        check("rst_store",   bus.ex_store_data,  32'd0);
        check("rst_dest",    32'(bus.ex_dest),   32'd0);
        check("rst_ctrl",    32'({bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we}), 32'd0);
        check("rst_hazard",  32'(bus.ld_use_hazard), 32'd0);

        // Plain ADD r3 = r1 + r2.
        rst = 1'b0;
        clear_fwd();
        drive_id(1'b1, 32'h100, ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7,
                 32'h0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("add_opnd1",   bus.ALUopnd1,       32'd5);
        check("add_opnd2",   bus.ALUopnd2,       32'd7);
        check("add_valid",   32'(bus.ex_valid),  32'd1);
        check("add_pc",      bus.ex_pc,          32'h100);
        check("add_aluop",   32'(bus.ALUop),     32'(ALU_ADD));
        check("add_dest",    32'(bus.ex_dest),   32'd3);
        check("add_reg_we",  32'(bus.ex_reg_we), 32'd1);

        // Forward priority on rs = r3 with a stored value of 1.
        drive_id(1'b1, 32'h104, ALU_OR, 5'd3, 32'd1, 5'd5, 32'd9,
                 32'h0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        check("fwd_none",    bus.ALUopnd1,       32'd1);
        bus.mem_fwd_we   = 1'b1;
        bus.mem_fwd_addr = 5'd3;
        bus.mem_fwd_data = 32'hAA;
        bus.wb_fwd_we    = 1'b1;
        bus.wb_fwd_addr  = 5'd3;
        bus.wb_fwd_data  = 32'hBB;
        settle();
        check("fwd_mem_win", bus.ALUopnd1,       32'hAA);
        check("fwd_rt_kept", bus.ALUopnd2,       32'd9);
        bus.mem_fwd_we = 1'b0;
        settle();
        check("fwd_wb",      bus.ALUopnd1,       32'hBB);
        // A forward from register 0 must never be used.
        drive_id(1'b1, 32'h108, ALU_AND, 5'd0, 32'd1, 5'd0, 32'd2,
                 32'h0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        clear_fwd();
        tick();
        bus.mem_fwd_we   = 1'b1;
        bus.mem_fwd_addr = 5'd0;
        bus.mem_fwd_data = 32'hAA;
        bus.wb_fwd_we    = 1'b1;
        bus.wb_fwd_addr  = 5'd0;
        bus.wb_fwd_data  = 32'hBB;
        settle();
        check("fwd_r0_rs",   bus.ALUopnd1,       32'd1);
        check("fwd_r0_rt",   bus.ALUopnd2,       32'd2);

        // Load-use: lw r4, 4(r1), then sw r4, 8(r6).
        clear_fwd();
        drive_id(1'b1, 32'h200, ALU_ADD, 5'd1, 32'h10, 5'd0, 32'h0,
                 32'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        check("lw_mem_re",   32'(bus.ex_mem_re), 32'd1);
        check("lw_opnd2",    bus.ALUopnd2,       32'd4);
        drive_id(1'b1, 32'h204, ALU_ADD, 5'd6, 32'h200, 5'd4, 32'hDEAD,
                 32'd8, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        settle();
        check("lu_hazard",   32'(bus.ld_use_hazard), 32'd1);
        tick();
        check("lu_bub_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bub_aluop", 32'(bus.ALUop),    32'd0);
        check("lu_bub_pc",   bus.ex_pc,          32'd0);
        check("lu_bub_ctrl", 32'({bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we}), 32'd0);
        check("lu_hz_clear", 32'(bus.ld_use_hazard), 32'd0);
        // The load is now in MEM.
        bus.mem_fwd_we   = 1'b1;
        bus.mem_fwd_addr = 5'd4;
        bus.mem_fwd_data = 32'hCAFE;
        tick();
        check("sw_pc",       bus.ex_pc,          32'h204);
        check("sw_store",    bus.ex_store_data,  32'hCAFE);
        check("sw_opnd1",    bus.ALUopnd1,       32'h200);
        check("sw_opnd2",    bus.ALUopnd2,       32'd8);
        check("sw_mem_we",   32'(bus.ex_mem_we), 32'd1);

        // Stall refresh: lw r8, 0(r2) held for three cycles. WB supplies r2
        // only in the first cycle. The ID instruction reads r8, but the
        // stall suppresses the hazard.
        clear_fwd();
        drive_id(1'b1, 32'h300, ALU_ADD, 5'd2, 32'h0, 5'd0, 32'h0,
                 32'd0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 32'h304, ALU_ADD, 5'd8, 32'h77, 5'd9, 32'h5,
                 32'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        bus.stall       = 1'b1;
        bus.wb_fwd_we   = 1'b1;
        bus.wb_fwd_addr = 5'd2;
        bus.wb_fwd_data = 32'h1234;
        settle();
        check("st_hz_mask",  32'(bus.ld_use_hazard), 32'd0);
        check("st_opnd1_c0", bus.ALUopnd1,       32'h1234);
        tick();
        clear_fwd();
        settle();
        check("st_opnd1_c1", bus.ALUopnd1,       32'h1234);
        tick();
        tick();
        check("st_opnd1_c3", bus.ALUopnd1,       32'h1234);
        check("st_hold_pc",  bus.ex_pc,          32'h300);
        check("st_hold_dst", 32'(bus.ex_dest),   32'd8);
        check("st_hold_re",  32'(bus.ex_mem_re), 32'd1);
        bus.stall = 1'b0;
        settle();
        check("st_rel_hz",   32'(bus.ld_use_hazard), 32'd1);
        tick();
        check("st_bubble",   32'(bus.ex_valid),  32'd0);
        tick();
        check("st_load_pc",  bus.ex_pc,          32'h304);

        // Flush and stall together: flush wins.
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        check("fl_valid",    32'(bus.ex_valid),  32'd0);
        check("fl_ctrl",     32'({bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we}), 32'd0);
        check("fl_dest",     32'(bus.ex_dest),   32'd0);
        check("fl_pc",       bus.ex_pc,          32'd0);

        // sll r10, r9, 31
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b1, 32'h400, ALU_SLL, 5'd0, 32'h0, 5'd9, 32'h40,
                 32'd0, 5'd31, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        check("sll_opnd1",   bus.ALUopnd1,       32'd31);
        check("sll_opnd2",   bus.ALUopnd2,       32'h40);
        check("sll_aluop",   32'(bus.ALUop),     32'(ALU_SLL));

        // Reset during a stall clears the register.
        bus.stall = 1'b1;
        rst       = 1'b1;
        tick();
        check("rs_st_valid", 32'(bus.ex_valid),  32'd0);
        check("rs_st_pc",    bus.ex_pc,          32'd0);
        check("rs_st_dest",  32'(bus.ex_dest),   32'd0);
        check("rs_st_opnd1", bus.ALUopnd1,       32'd0);
        rst       = 1'b0;
        bus.stall = 1'b0;
        settle();
        check("rs_st_after", bus.ALUopnd1,       32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
